// File: rtl/audio_pkg.sv
// Shared constants for the AC'97 controller: frame slot layout, tag word,
// codec register addresses and the fixed register values we program.
package audio_pkg;

  localparam logic [7:0] SLOT0_END    = 8'd15;
  localparam logic [7:0] SLOT1_END    = 8'd35;
  localparam logic [7:0] SLOT2_END    = 8'd55;
  localparam logic [7:0] SLOT3_END    = 8'd75;
  localparam logic [7:0] SLOT4_END    = 8'd95;
  localparam logic [7:0] IN_LATCH_BIT = 8'd63;

  // frame valid, cmd addr valid, cmd data valid, PCM left valid, PCM right valid
  localparam logic [15:0] TAG = 16'b1111_1000_0000_0000;

  localparam logic [6:0] REG_MASTER_VOL = 7'h02;
  localparam logic [6:0] REG_HP_VOL     = 7'h04;
  localparam logic [6:0] REG_PCM_OUT    = 7'h18;
  localparam logic [6:0] REG_REC_SEL    = 7'h1A;
  localparam logic [6:0] REG_REC_GAIN   = 7'h1C;
  localparam logic [6:0] REG_MIC_VOL    = 7'h0E;

  localparam logic [15:0] VAL_PCM_OUT  = 16'h0808;
  localparam logic [15:0] VAL_REC_SEL  = 16'h0000;
  localparam logic [15:0] VAL_REC_GAIN = 16'h0F0F;
  localparam logic [15:0] VAL_MIC_VOL  = 16'h8000;

  // Volume register word: {mute, 2'b0, att, 3'b0, att}, att counts down from max.
  function automatic logic [15:0] vol_word(input logic [4:0] vol);
    logic [4:0] att;
    att = 5'd31 - vol;
    return {(vol == 5'd0), 2'b00, att, 3'b000, att};
  endfunction

endpackage

// File: rtl/ac97_frame.sv
// AC'97 frame engine: samples the codec bit clock as data, tracks the bit position,
// serialises slots 0-4 onto sdata_out and deserialises the left ADC sample.
module ac97_frame
  import audio_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       bit_clock,
  input  logic       sdata_in,
  input  logic [6:0] cmd_addr,
  input  logic [15:0] cmd_data,
  input  logic [7:0] pcm_out,
  output logic       frame_start,
  output logic       sdata_out,
  output logic       synch,
  output logic [7:0] pcm_in,
  output logic       ready
);

  logic       bclk_s1, bclk_s2, bclk_q;
  logic       din_s1, din_s2;
  logic       rise, fall, started;
  logic [7:0] bit_count, nxt;
  logic [7:0] out_latch, in_hold;
  logic [6:0] in_shift;
  logic       tx_bit;
  logic [19:0] slot1, slot2, slot34;

  assign rise        = en & bclk_s2 & ~bclk_q;
  assign fall        = en & ~bclk_s2 & bclk_q;
  assign frame_start = rise & (bit_count == 8'hFF);

  assign slot1  = {1'b0, cmd_addr, 12'h000};
  assign slot2  = {cmd_data, 4'h0};
  assign slot34 = {out_latch, 12'h000};

  // Bit value for the position the counter is about to enter.
  always_comb begin
    nxt    = bit_count + 8'd1;
    tx_bit = 1'b0;
    if (nxt <= SLOT0_END)      tx_bit = TAG[4'(SLOT0_END - nxt)];
    else if (nxt <= SLOT1_END) tx_bit = slot1[5'(SLOT1_END - nxt)];
    else if (nxt <= SLOT2_END) tx_bit = slot2[5'(SLOT2_END - nxt)];
    else if (nxt <= SLOT3_END) tx_bit = slot34[5'(SLOT3_END - nxt)];
    else if (nxt <= SLOT4_END) tx_bit = slot34[5'(SLOT4_END - nxt)];
  end

  // ready: single-cycle pulse; pcm_in is valid with it and pcm_out was consumed at that frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_s1   <= 1'b0;
      bclk_s2   <= 1'b0;
      bclk_q    <= 1'b0;
      din_s1    <= 1'b0;
      din_s2    <= 1'b0;
      bit_count <= 8'hFF;
      sdata_out <= 1'b0;
      synch     <= 1'b0;
      started   <= 1'b0;
      out_latch <= 8'h00;
      in_shift  <= 7'h00;
      in_hold   <= 8'h00;
      pcm_in    <= 8'h00;
      ready     <= 1'b0;
    end else begin
      bclk_s1 <= bit_clock;
      bclk_s2 <= bclk_s1;
      bclk_q  <= bclk_s2;
      // Serial input rides the same delay as the bit clock so the fall strobe
      // sees the bit the codec held across that edge, not the next one.
      din_s1  <= sdata_in;
      din_s2  <= din_s1;
      ready   <= 1'b0;
      if (rise) begin
        bit_count <= nxt;
        sdata_out <= tx_bit;
        synch     <= (nxt <= SLOT0_END);
        started   <= 1'b1;
        if (nxt == 8'd0) begin
          out_latch <= pcm_out;
          if (started) begin
            ready  <= 1'b1;
            pcm_in <= in_hold;
          end
        end
      end
      if (fall) begin
        in_shift <= {in_shift[5:0], din_s2};
        if (bit_count == IN_LATCH_BIT) in_hold <= {in_shift, din_s2};
      end
    end
  end

endmodule

// File: rtl/audio.sv
// AC'97 codec controller top: codec reset timer, rotating register-write list
// with volume mapping, and the frame engine.
module audio
  import audio_pkg::*;
#(
  parameter int RESET_CYCLES = 1024,
  parameter int NUM_CMDS     = 6
) (
  input  logic       clock_27mhz,
  input  logic       reset,
  input  logic [4:0] volume,
  input  logic [7:0] audio_out_data,
  output logic [7:0] audio_in_data,
  output logic       ready,
  output logic       audio_reset_b,
  output logic       ac97_sdata_out,
  input  logic       ac97_sdata_in,
  output logic       ac97_synch,
  input  logic       ac97_bit_clock
);

  localparam int RST_W = $clog2(RESET_CYCLES);

  logic [RST_W-1:0] rst_cnt;
  logic [2:0]       cmd_idx;
  logic [6:0]       rom_addr, cmd_addr_q;
  logic [15:0]      rom_data, cmd_data_q;
  logic             frame_start;

  always_comb begin
    rom_addr = 7'h00;
    rom_data = 16'h0000;
    case (cmd_idx)
      3'd0: begin rom_addr = REG_MASTER_VOL; rom_data = vol_word(volume); end
      3'd1: begin rom_addr = REG_HP_VOL;     rom_data = vol_word(volume); end
      3'd2: begin rom_addr = REG_PCM_OUT;    rom_data = VAL_PCM_OUT;      end
      3'd3: begin rom_addr = REG_REC_SEL;    rom_data = VAL_REC_SEL;      end
      3'd4: begin rom_addr = REG_REC_GAIN;   rom_data = VAL_REC_GAIN;     end
      3'd5: begin rom_addr = REG_MIC_VOL;    rom_data = VAL_MIC_VOL;      end
      default: ;
    endcase
  end

  // The command for a frame is captured at its start so the first frame carries entry 0.
  always_ff @(posedge clock_27mhz or negedge reset) begin
    if (!reset) begin
      rst_cnt       <= '0;
      audio_reset_b <= 1'b0;
      cmd_idx       <= 3'd0;
      cmd_addr_q    <= 7'h00;
      cmd_data_q    <= 16'h0000;
    end else begin
      if (!audio_reset_b) begin
        rst_cnt <= rst_cnt + RST_W'(1);
        if (rst_cnt == RST_W'(RESET_CYCLES - 1)) audio_reset_b <= 1'b1;
      end
      if (frame_start) begin
        cmd_addr_q <= rom_addr;
        cmd_data_q <= rom_data;
        cmd_idx    <= (cmd_idx == 3'(NUM_CMDS - 1)) ? 3'd0 : cmd_idx + 3'd1;
      end
    end
  end

  ac97_frame u_frame (
    .clk         (clock_27mhz),
    .rst_n       (reset),
    .en          (audio_reset_b),
    .bit_clock   (ac97_bit_clock),
    .sdata_in    (ac97_sdata_in),
    .cmd_addr    (cmd_addr_q),
    .cmd_data    (cmd_data_q),
    .pcm_out     (audio_out_data),
    .frame_start (frame_start),
    .sdata_out   (ac97_sdata_out),
    .synch       (ac97_synch),
    .pcm_in      (audio_in_data),
    .ready       (ready)
  );

endmodule

// File: tb/tb_audio.sv
// Directed bench for the AC'97 controller: bench-driven bit clock at clk/4,
// codec-side serial model, frame capture and slot-by-slot comparison.
module tb_audio;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] volume = 5'd31;
  logic [7:0] pcm_out = 8'h00;
  logic [7:0] pcm_in;
  logic       ready;
  logic       codec_rst_b;
  logic       sdata_out;
  logic       sdata_in = 1'b0;
  logic       synch;
  logic       bclk = 1'b0;

  int n_checks = 0;
  int n_fail = 0;
  int ready_cnt = 0;
  int base;
  int n;

  logic [0:255] rx_bits, rx_sync;

  // Per-frame directed vectors after the codec comes out of reset.
  logic [4:0]  vol_tab  [8] = '{5'd31, 5'd0, 5'd5, 5'd5, 5'd5, 5'd5, 5'd16, 5'd31};
  logic [7:0]  pcm_tab  [8] = '{8'hA5, 8'h5A, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h3C, 8'hC3};
  logic [6:0]  addr_tab [8] = '{7'h02, 7'h04, 7'h18, 7'h1A, 7'h1C, 7'h0E, 7'h02, 7'h04};
  logic [15:0] data_tab [8] = '{16'h0000, 16'h9F1F, 16'h0808, 16'h0000, 16'h0F0F, 16'h8000,
                                16'h0F0F, 16'h0000};
  logic [7:0]  in_tab   [8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h3C, 8'hFF, 8'hFF, 8'hFF};

  always #5 clk = ~clk;

  audio dut (
    .clock_27mhz    (clk),
    .reset          (rst_n),
    .volume         (volume),
    .audio_out_data (pcm_out),
    .audio_in_data  (pcm_in),
    .ready          (ready),
    .audio_reset_b  (codec_rst_b),
    .ac97_sdata_out (sdata_out),
    .ac97_sdata_in  (sdata_in),
    .ac97_synch     (synch),
    .ac97_bit_clock (bclk)
  );

  always @(negedge clk) if (ready) ready_cnt++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Release reset on a falling edge and count rising edges until the codec reset lifts.
  task automatic release_and_wait(output int cycles);
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    while (cycles < 2000 && !codec_rst_b) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // Put bit clock edges 3 ns before a rising clk edge.
  task automatic align;
    @(posedge clk);
    #7;
  endtask

  // One bit period per index; codec drives codec_byte on bits 56..63, 1 elsewhere.
  task automatic run_bits(input int first, input int last, input logic [7:0] codec_byte);
    for (int b = first; b <= last; b++) begin
      sdata_in = (b >= 56 && b <= 63) ? codec_byte[63 - b] : 1'b1;
      bclk = 1'b1;
      #20;
      bclk = 1'b0;
      #18;
      rx_bits[b] = sdata_out;
      rx_sync[b] = synch;
      #2;
    end
  endtask

  task automatic check_frame(input string pfx, input logic [6:0] addr, input logic [15:0] data,
                             input logic [7:0] pcm);
    check_eq({pfx, "_slot0"}, 32'(rx_bits[0:15]), 32'h0000F800);
    check_eq({pfx, "_slot1"}, 32'(rx_bits[16:35]), 32'({1'b0, addr, 12'h000}));
    check_eq({pfx, "_slot2"}, 32'(rx_bits[36:55]), 32'({data, 4'h0}));
    check_eq({pfx, "_slot3"}, 32'(rx_bits[56:75]), 32'({pcm, 12'h000}));
    check_eq({pfx, "_slot4"}, 32'(rx_bits[76:95]), 32'({pcm, 12'h000}));
    check_eq({pfx, "_slots5_12"}, 32'($countones(rx_bits[96:255])), 32'd0);
    check_eq({pfx, "_synch_head"}, 32'(rx_sync[0:31]), 32'hFFFF0000);
    check_eq({pfx, "_synch_count"}, 32'($countones(rx_sync)), 32'd16);
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_in_data", 32'(pcm_in), 32'h0);
    check_eq("rst_ready", 32'(ready), 32'h0);
    check_eq("rst_codec_rst_b", 32'(codec_rst_b), 32'h0);
    check_eq("rst_sdata_out", 32'(sdata_out), 32'h0);
    check_eq("rst_synch", 32'(synch), 32'h0);

    release_and_wait(n);
    check_eq("codec_reset_delay", 32'(n), 32'd1024);
    check_eq("frame_idle_before_clock", 32'(synch), 32'h0);

    align;
    for (int f = 0; f < 8; f++) begin
      volume  = vol_tab[f];
      pcm_out = pcm_tab[f];
      run_bits(0, 255, (f == 3) ? 8'h3C : 8'hFF);
      check_frame($sformatf("f%0d", f), addr_tab[f], data_tab[f], pcm_tab[f]);
      check_eq($sformatf("f%0d_ready_count", f), 32'(ready_cnt), 32'(f));
      check_eq($sformatf("f%0d_in_data", f), 32'(pcm_in), 32'(in_tab[f]));
    end

    // Bit clock stopped: nothing advances.
    base = ready_cnt;
    repeat (200) @(posedge clk);
    #1;
    check_eq("stopped_ready", 32'(ready_cnt), 32'(base));
    check_eq("stopped_synch", 32'(synch), 32'h0);
    check_eq("stopped_sdata_out", 32'(sdata_out), 32'h0);

    // Resume, then reset in the middle of the frame.
    align;
    run_bits(0, 100, 8'hFF);
    check_eq("resume_ready", 32'(ready_cnt), 32'(base + 1));
    check_eq("resume_in_data", 32'(pcm_in), 32'hFF);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_in_data", 32'(pcm_in), 32'h0);
    check_eq("midrst_codec_rst_b", 32'(codec_rst_b), 32'h0);
    check_eq("midrst_ready", 32'(ready), 32'h0);
    check_eq("midrst_synch", 32'(synch), 32'h0);
    check_eq("midrst_sdata_out", 32'(sdata_out), 32'h0);
    repeat (3) @(posedge clk);

    release_and_wait(n);
    check_eq("codec_reset_delay2", 32'(n), 32'd1024);
    align;
    volume  = 5'd31;
    pcm_out = 8'h66;
    base    = ready_cnt;
    run_bits(0, 255, 8'hFF);
    check_frame("restart", 7'h02, 16'h0000, 8'h66);
    check_eq("restart_no_ready", 32'(ready_cnt), 32'(base));
    check_eq("restart_in_data", 32'(pcm_in), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
